// File: rtl/seq_countdown_pkg.sv
// seq_countdown_pkg: shared state encoding and width limit for the countdown timer.
package seq_countdown_pkg;
    localparam int CD_WIDTH_MAX = 32;
    typedef enum logic [1:0] {IDLE, RUN, PAUSED} cd_state_e;
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down-counter that saturates at zero and flags it.
module seq_down_counter
    import seq_countdown_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero
);
    assign zero = count == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (load) count <= load_value;
        else if (en && !zero) count <= count - WIDTH'(1);
    end
endmodule

// File: rtl/seq_countdown_timer.sv
// seq_countdown_timer: loadable countdown timer with valid/ready load and one-cycle done pulse.
// Define SEQ_COUNTDOWN_AUTORELOAD_EN to restart from the last loaded value on every completion.
module seq_countdown_timer
    import seq_countdown_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);
    cd_state_e state;
    logic accept, kill, run, last, ld, zero;
    logic [WIDTH-1:0] ld_value;
    assign load_ready = state == IDLE;
    always_comb begin
        accept = load_valid && load_ready;
        kill = abort && !load_ready;
        run = state == RUN && !abort && !pause;
        last = run && count == WIDTH'(1);
    end
`ifdef SEQ_COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reload <= '0;
        else if (accept) reload <= load_value;
    end
    assign ld = accept || kill || last;
    assign ld_value = kill ? '0 : accept ? load_value : reload;
`else
    assign ld = accept || kill;
    assign ld_value = kill ? '0 : load_value;
`endif
    seq_down_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .load(ld),
        .en(run && !zero),
        .load_value(ld_value),
        .count(count),
        .zero(zero)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (accept && load_value == '0) || last;
            case (state)
                IDLE: if (accept && load_value != '0) begin
                    state <= RUN;
                    busy <= 1'b1;
                end
                RUN: if (abort) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else if (pause) state <= PAUSED;
                else if (last) begin
`ifdef SEQ_COUNTDOWN_AUTORELOAD_EN
                    state <= RUN;
`else
                    state <= IDLE;
                    busy <= 1'b0;
`endif
                end
                PAUSED: if (abort) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else if (!pause) state <= RUN;
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_countdown_timer.sv
// tb_seq_countdown_timer: scoreboard bench for the countdown timer (WIDTH=8).
module tb_seq_countdown_timer;
    logic clk = 1'b0, rst_n = 1'b0, load_valid = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic load_ready, busy, done;
    logic [7:0] count;
    int checks = 0, failures = 0;
    logic [10:0] sbq[$];
    logic [10:0] obs, e;

    always #5 clk = ~clk;

    seq_countdown_timer #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .pause(pause),
        .abort(abort),
        .count(count),
        .busy(busy),
        .done(done)
    );

    assign obs = {count, busy, done, load_ready};

    function automatic logic [10:0] pk(int c, bit b, bit d, bit r);
        return {8'(c), b, d, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_valid = 1'b1;
        load_value = 8'd9;
        repeat (2) tick();
        sbq.push_back(pk(0, 0, 0, 1));
        e = sbq.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
        end
        rst_n = 1'b1;
        load_valid = 1'b0;
        sbq.push_back(pk(0, 0, 0, 1));
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL post_reset got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic test_load5();
        for (int c = 0; c <= 6; c++) begin
            load_valid = c == 0;
            load_value = 8'd5;
            sbq.push_back(c < 5 ? pk(5 - c, 1, 0, 0) : c == 5 ? pk(0, 0, 1, 1) : pk(0, 0, 0, 1));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL load5 c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_load_zero();
        for (int c = 0; c <= 1; c++) begin
            load_valid = c == 0;
            load_value = 8'd0;
            sbq.push_back(c == 0 ? pk(0, 0, 1, 1) : pk(0, 0, 0, 1));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL load0 c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_pause();
        int ec[10] = '{4, 3, 3, 3, 3, 3, 2, 1, 0, 0};
        for (int c = 0; c <= 9; c++) begin
            load_valid = c == 0;
            load_value = 8'd4;
            pause = c >= 2 && c <= 4;
            sbq.push_back(c <= 7 ? pk(ec[c], 1, 0, 0) : c == 8 ? pk(0, 0, 1, 1) : pk(0, 0, 0, 1));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL pause c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
        load_valid = 1'b0;
        pause = 1'b0;
    endtask

    task automatic test_abort();
        for (int c = 0; c <= 54; c++) begin
            load_valid = c == 0;
            load_value = 8'd200;
            abort = c == 51;
            sbq.push_back(c <= 50 ? pk(200 - c, 1, 0, 0) : pk(0, 0, 0, 1));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
        for (int c = 0; c <= 4; c++) begin
            load_valid = c == 0;
            load_value = 8'd10;
            abort = c == 2;
            pause = c == 2;
            sbq.push_back(c < 2 ? pk(10 - c, 1, 0, 0) : pk(0, 0, 0, 1));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_pause c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
        for (int c = 0; c <= 5; c++) begin
            load_valid = c == 0 || c == 4;
            load_value = c == 0 ? 8'd10 : 8'd1;
            pause = c == 2 || c == 3;
            abort = c == 3;
            sbq.push_back(c == 0 ? pk(10, 1, 0, 0) : c <= 2 ? pk(9, 1, 0, 0) : c == 3 ? pk(0, 0, 0, 1) :
                          c == 4 ? pk(1, 1, 0, 0) : pk(0, 0, 1, 1));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_paused c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
        load_valid = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        tick();
    endtask

    task automatic test_reset_midrun();
        for (int c = 0; c <= 19; c++) begin
            load_valid = c == 0;
            load_value = 8'd255;
            sbq.push_back(pk(255 - c, 1, 0, 0));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL max_run c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
        #2;
        rst_n = 1'b0;
        load_valid = 1'b1;
        load_value = 8'd7;
        sbq.push_back(pk(0, 0, 0, 1));
        #1;
        e = sbq.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL async_reset got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
        end
        sbq.push_back(pk(0, 0, 0, 1));
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL held_reset got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
        end
        load_value = 8'd1;
        #3;
        rst_n = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            sbq.push_back(c == 0 ? pk(1, 1, 0, 0) : c == 1 ? pk(0, 0, 1, 1) : pk(0, 0, 0, 1));
            tick();
            load_valid = 1'b0;
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL load1 c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ec[8] = '{2, 1, 0, 3, 2, 1, 0, 0};
        bit eb[8] = '{1, 1, 0, 1, 1, 1, 0, 0};
        bit ed[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
        for (int c = 0; c <= 7; c++) begin
            load_valid = c <= 3;
            load_value = c < 3 ? 8'd2 : 8'd3;
            sbq.push_back(pk(ec[c], eb[c], ed[c], !eb[c]));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL b2b c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_autoreload();
        for (int c = 0; c <= 15; c++) begin
            load_valid = c == 0;
            load_value = 8'd3;
            abort = c == 14;
            sbq.push_back(c >= 14 ? pk(0, 0, 0, 1) : pk(3 - (c % 3), 1, c > 0 && c % 3 == 0, 0));
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL autoreload c=%0d got c/b/d/r=%0d/%b/%b/%b exp=%0d/%b/%b/%b", c, count, busy, done, load_ready, e[10:3], e[2], e[1], e[0]);
            end
        end
        load_valid = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_zero();
`ifdef SEQ_COUNTDOWN_AUTORELOAD_EN
        test_autoreload();
`else
        test_load5();
        test_pause();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
